// File: rtl/rv_mem_pkg.sv
// Shared RV32I data-memory definitions: funct3 width codes and responder FSM states.
package rv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half/word out of a memory word and extends it per funct3.
module dmem_load_align
   import rv_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (offset)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];

      rdata = '0;
      case (funct3)
         F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   rdata = {24'd0, byte_sel};
         F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
         F3_HU:   rdata = {16'd0, half_sel};
         F3_W:    rdata = word;
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-port byte-writable data memory behind a valid/ready request port.
// One request per three cycles: IDLE accepts, ACCESS reads/commits, RESP strobes the result.
module dmem_responder
   import rv_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   state_t      state;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [2:0]  lat_f3;

   logic [31:0] offset;
   logic        in_range;
   logic        bad_width;
   logic        acc_err;
   logic [IW-1:0] idx;
   logic [31:0] rd_word;
   logic [31:0] ld_data;
   logic [3:0]  lane_en;
   logic [31:0] lane_dat;
   logic        wr_en;

   logic [31:0] mem [DEPTH_WORDS];

   // Range test works on the offset so ADDR_BASE near 2^32 cannot wrap the upper bound.
   always_comb begin
      offset   = lat_addr - ADDR_BASE;
      in_range = (lat_addr >= ADDR_BASE) && ({1'b0, offset} < SPAN);
      idx      = offset[IW+1:2];
      rd_word  = in_range ? mem[idx] : '0;
   end

   always_comb begin
      bad_width = 1'b1;
      case (lat_f3)
         F3_B:    bad_width = 1'b0;
         F3_H:    bad_width = lat_addr[0];
         F3_W:    bad_width = |lat_addr[1:0];
         F3_BU:   bad_width = lat_we;
         F3_HU:   bad_width = lat_we | lat_addr[0];
         default: bad_width = 1'b1;
      endcase
      acc_err = bad_width | ~in_range;
   end

   always_comb begin
      lane_en  = 4'b0000;
      lane_dat = lat_wdata;
      case (lat_f3)
         F3_B: begin
            lane_en  = 4'b0001 << lat_addr[1:0];
            lane_dat = {4{lat_wdata[7:0]}};
         end
         F3_H: begin
            lane_en  = lat_addr[1] ? 4'b1100 : 4'b0011;
            lane_dat = {2{lat_wdata[15:0]}};
         end
         F3_W: begin
            lane_en  = 4'b1111;
            lane_dat = lat_wdata;
         end
         default: begin
            lane_en  = 4'b0000;
            lane_dat = lat_wdata;
         end
      endcase
      wr_en = (state == ST_ACCESS) && lat_we && !acc_err && !reset;
   end

   dmem_load_align u_align (
      .word   (rd_word),
      .offset (lat_addr[1:0]),
      .funct3 (lat_f3),
      .rdata  (ld_data)
   );

   // Array contents survive reset; only the commit enable sees it.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               mem[idx][8*i +: 8] <= lane_dat[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_f3    <= F3_W;
      end else begin
         case (state)
            ST_IDLE: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_f3    <= req_funct3;
                  req_ready <= 1'b0;
                  state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               rsp_valid <= 1'b1;
               rsp_err   <= acc_err;
               rsp_rdata <= (acc_err || lat_we) ? '0 : ld_data;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: requests queue expected responses, a negedge monitor checks them.
module tb_dmem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   cyc        = 0;
   bit   mon_en     = 1'b0;

   dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0000_0000)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Response monitor: every strobe must match the oldest expectation, idle cycles must be zero.
   always @(negedge clock) begin
      if (mon_en) begin
         if (rsp_valid === 1'b1) begin
            vectors++;
            assert (sb.size() != 0) else begin
               miscompares++;
               $error("FAIL unexpected_rsp observed=%h expected=none", rsp_rdata);
            end
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
               chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
         end else begin
            chk("idle_zero", {rsp_err, rsp_rdata[30:0]} | {31'd0, rsp_rdata[31]}, 32'd0);
            chk("rsp_valid_known", 32'(rsp_valid), 32'd0);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge with req_valid still high.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] er, input logic ee,
                        input bit push, output int hs);
      int n;
      n = 0;
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      hs = -1;
      vectors++;
      assert (req_ready === 1'b1) else begin
         miscompares++;
         $error("FAIL handshake_timeout observed=%b expected=1", req_ready);
      end
      if (req_ready === 1'b1) begin
         hs = cyc;
         if (push) sb.push_back('{er, ee, cyc + 2});
         @(negedge clock);
      end
   endtask

   task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic [31:0] er, input logic ee);
      int hs;
      issue(we, addr, wdata, f3, er, ee, 1'b1, hs);
      req_valid = 1'b0;
   endtask

   initial begin
      int h0, h1, h2, h3, n;
      reset = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      req_funct3 = 3'b010;
      repeat (3) @(negedge clock);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      reset = 1'b0;
      chk("ready_after_reset", 32'(req_ready), 32'd1);
      mon_en = 1'b1;

      // Known background words
      req(1, 32'h0000_0000, 32'h1111_1111, 3'b010, 32'h0, 0);
      req(1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0, 0);
      req(0, 32'h0000_0010, 32'h0,         3'b010, 32'hDEAD_BEEF, 0);

      // Byte store and sign/zero extended byte loads
      req(1, 32'h0000_0013, 32'hAAAA_AA80, 3'b000, 32'h0, 0);
      req(0, 32'h0000_0013, 32'h0,         3'b000, 32'hFFFF_FF80, 0);
      req(0, 32'h0000_0013, 32'h0,         3'b100, 32'h0000_0080, 0);
      req(0, 32'h0000_0010, 32'h0,         3'b010, 32'h80AD_BEEF, 0);

      // Halfword store on a restored word
      req(1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0, 0);
      req(1, 32'h0000_0012, 32'h5555_1234, 3'b001, 32'h0, 0);
      req(0, 32'h0000_0012, 32'h0,         3'b101, 32'h0000_1234, 0);
      req(0, 32'h0000_0010, 32'h0,         3'b010, 32'h1234_BEEF, 0);
      req(0, 32'h0000_0011, 32'h0,         3'b001, 32'h0, 1);
      req(0, 32'h0000_0010, 32'h0,         3'b001, 32'hFFFF_BEEF, 0);
      req(0, 32'h0000_0010, 32'h0,         3'b101, 32'h0000_BEEF, 0);
      req(0, 32'h0000_0010, 32'h0,         3'b000, 32'hFFFF_FFEF, 0);
      req(0, 32'h0000_0011, 32'h0,         3'b100, 32'h0000_00BE, 0);

      // Range boundary: last word is legal, one past it errors and writes nothing
      req(1, 32'h0000_0FFC, 32'h0BAD_F00D, 3'b010, 32'h0, 0);
      req(0, 32'h0000_0FFC, 32'h0,         3'b010, 32'h0BAD_F00D, 0);
      req(1, 32'h0000_1000, 32'h7777_7777, 3'b010, 32'h0, 1);
      req(0, 32'h0000_1000, 32'h0,         3'b000, 32'h0, 1);
      req(0, 32'h0000_0000, 32'h0,         3'b010, 32'h1111_1111, 0);
      req(0, 32'h0000_0FFC, 32'h0,         3'b010, 32'h0BAD_F00D, 0);

      // Misaligned and illegal width codes
      req(1, 32'h0000_0012, 32'h9999_9999, 3'b010, 32'h0, 1);
      req(1, 32'h0000_0011, 32'h9999_9999, 3'b001, 32'h0, 1);
      req(1, 32'h0000_0010, 32'h9999_9999, 3'b100, 32'h0, 1);
      req(0, 32'h0000_0010, 32'h0,         3'b011, 32'h0, 1);
      req(0, 32'h0000_0010, 32'h0,         3'b110, 32'h0, 1);
      req(0, 32'h0000_0010, 32'h0,         3'b010, 32'h1234_BEEF, 0);

      // Reset during ACCESS drops the store and its response
      req(1, 32'h0000_0020, 32'hCAFE_F00D, 3'b010, 32'h0, 0);
      issue(1, 32'h0000_0020, 32'h0000_0055, 3'b010, 32'h0, 0, 1'b0, h0);
      reset = 1'b1;
      req_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      chk("ready_after_midreset", 32'(req_ready), 32'd1);
      @(negedge clock);
      req(0, 32'h0000_0020, 32'h0, 3'b010, 32'hCAFE_F00D, 0);

      // req_valid held with a new request presented right after each accept
      issue(1, 32'h0000_0030, 32'h0102_0304, 3'b010, 32'h0, 0, 1'b1, h0);
      issue(0, 32'h0000_0030, 32'h0,         3'b010, 32'h0102_0304, 0, 1'b1, h1);
      issue(1, 32'h0000_0031, 32'h0000_00FF, 3'b000, 32'h0, 0, 1'b1, h2);
      issue(0, 32'h0000_0030, 32'h0,         3'b010, 32'h0102_FF04, 0, 1'b1, h3);
      req_valid = 1'b0;
      chk("gap01", 32'(h1 - h0), 32'd3);
      chk("gap12", 32'(h2 - h1), 32'd3);
      chk("gap23", 32'(h3 - h2), 32'd3);

      n = 0;
      while (sb.size() != 0 && n < 10) begin
         @(negedge clock);
         n++;
      end
      repeat (3) @(negedge clock);
      chk("drain", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter: DEPTH_WORDS, 1024, number of 32-bit words in the internal data array.
REQ-002 SHALL have parameter: ADDR_BASE, 32'h0000_0000, byte address mapped to word 0.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned, out-of-range or illegal funct3; valid with rsp_valid.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; a handshake is req_valid && req_ready.
REQ-017 On handshake at edge N, SHALL latch we/addr/wdata/funct3 and enter ACCESS; inputs SHALL be ignored outside IDLE.
REQ-018 ACCESS SHALL read word index (addr-ADDR_BASE)>>2 and, for a legal store, commit the byte-lane write at the end of that cycle.
REQ-019 Store lanes, little-endian: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four; other lanes SHALL be unchanged.
REQ-020 Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
REQ-021 RESP SHALL assert rsp_valid for exactly one cycle, two cycles after the accepting edge (handshake edge N -> rsp_valid high in cycle N+2), then return to IDLE; req_ready SHALL be high again in cycle N+3.
REQ-022 Error if any of: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 not in {000,001,010,100,101} (for stores only 000,001,010 are legal); addr < ADDR_BASE or addr >= ADDR_BASE + 4*DEPTH_WORDS.
REQ-023 On error SHALL not write memory; SHALL drive rsp_err=1 and rsp_rdata=0 in RESP.
REQ-024 rsp_rdata and rsp_err SHALL be 0 in every cycle rsp_valid is 0.
REQ-025 Maximum throughput SHALL be one request per 3 cycles; a request held through RESP SHALL be accepted on the following IDLE cycle.
REQ-026 Address arithmetic SHALL be 32-bit unsigned; the range check SHALL not wrap for ADDR_BASE near 2^32.

Reset
REQ-027 When reset=1 at an edge, state SHALL become IDLE and rsp_valid, rsp_err and rsp_rdata SHALL become 0.
REQ-028 Reset SHALL take priority over a store commit in the same cycle; an in-flight request SHALL be dropped with no response.
REQ-029 Memory array contents SHALL NOT be reset.
REQ-030 req_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-031 Shared package rv_mem_pkg SHALL hold funct3 width constants (B/H/W/BU/HU) and the FSM state encoding.
REQ-032 Load extraction/extension SHALL be one combinational sub-module, dmem_load_align (word, addr[1:0], funct3 -> rdata).
REQ-033 The array SHALL be a single-port, byte-lane-writable register array inferred inside dmem_responder.

Verification
REQ-034 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid at N+2, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 Then SB 0x80 @0x13; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-036 SH 0x1234 @0x12, then LHU @0x12 -> 0x00001234 and LW @0x10 -> 0x1234BEEF (after REQ-034 data); LH @0x11 -> rsp_err=1, rsp_rdata=0.
REQ-037 SW @0x1000 with DEPTH_WORDS=1024 -> rsp_err=1; no array word modified.
REQ-038 Reset asserted in the ACCESS cycle of SW 0x55 @0x20 -> no rsp_valid; later LW @0x20 returns the prior value; req_ready=1 in the first cycle after reset deasserts.
REQ-039 req_valid held continuously with changing requests -> accepts only in IDLE, one rsp_valid per 3 cycles, responses in request order.
